// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: data width, LSU access-size codes and the
// data-memory controller state encoding.
package riscv_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [2:0] SIZE_B = 3'b000;
  localparam logic [2:0] SIZE_H = 3'b001;
  localparam logic [2:0] SIZE_W = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } dmem_state_t;

  // Illegal size codes behave as a full word access.
  function automatic logic [2:0] norm_size(input logic [2:0] size);
    if (size == SIZE_B || size == SIZE_H) return size;
    return SIZE_W;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic for the data-memory controller: byte enables,
// store-data lane replication, load-data right-justification/masking and
// misalignment detection.
// Build option: DMEM_CTRL_MISALIGN_CHECK_EN -- when defined, misaligned
// accesses are flagged; otherwise the low address bits are forced to the
// natural alignment of the access and the flag stays 0.
module dmem_align
  import riscv_pkg::*;
#(
  parameter int XLEN = RV_XLEN
) (
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        size,
  input  logic [XLEN-1:0]   store_data,
  input  logic [1:0]        ld_addr_lo,
  input  logic [2:0]        ld_size,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   ld_data,
  output logic [1:0]        eff_addr_lo,
  output logic [2:0]        eff_size,
  output logic              misaligned
);

  logic [XLEN-1:0] shifted;

  // Request side: effective offset, misalignment, byte enables and store lanes.
  always_comb begin
    eff_size    = norm_size(size);
    eff_addr_lo = addr_lo;
    misaligned  = 1'b0;
`ifdef DMEM_CTRL_MISALIGN_CHECK_EN
    case (eff_size)
      SIZE_H:  misaligned = addr_lo[0];
      SIZE_W:  misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
`else
    case (eff_size)
      SIZE_H:  eff_addr_lo = {addr_lo[1], 1'b0};
      SIZE_W:  eff_addr_lo = 2'b00;
      default: eff_addr_lo = addr_lo;
    endcase
`endif
    case (eff_size)
      SIZE_B: begin
        be    = 4'b0001 << eff_addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      SIZE_H: begin
        be    = 4'b0011 << eff_addr_lo;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  // Response side: shift the addressed lanes down and clear bits above the size.
  always_comb begin
    shifted = rdata >> {ld_addr_lo, 3'b000};
    case (norm_size(ld_size))
      SIZE_B:  ld_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      SIZE_H:  ld_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns the execute stage's single-cycle LSU access
// into a req/gnt/rvalid bus transaction, stalls the pipe until the response
// returns and hands right-justified load data back in the DONE cycle.
// Build option: DMEM_CTRL_MISALIGN_CHECK_EN enables misaligned-access
// suppression (see dmem_align).
//
// state | meaning
// IDLE  | no access in flight; a valid aligned access issues req here
// REQ   | request outstanding, waiting for gnt
// WAIT  | granted, waiting for rvalid
// DONE  | response (or timeout) presented for one cycle, stall released
module dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN           = RV_XLEN,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              adr_v_i,
  input  logic [XLEN-1:0]   adr_i,
  input  logic              is_store_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [2:0]        access_size_i,
  output logic [XLEN-1:0]   load_data_o,
  output logic              stall_o,
  output logic              misaligned_o,
  output logic              bus_err_o,
  output logic              req_o,
  input  logic              gnt_i,
  output logic              we_o,
  output logic [XLEN/8-1:0] be_o,
  output logic [XLEN-1:0]   addr_o,
  output logic [XLEN-1:0]   wdata_o,
  input  logic              rvalid_i,
  input  logic [XLEN-1:0]   rdata_i,
  input  logic              err_i
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  dmem_state_t state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        hit;

  logic        req, stall, mis_pulse;
  logic        cap_req, cap_rsp, cap_to;

  logic [1:0]        cap_lo;
  logic [2:0]        cap_size;
  logic              cap_store;
  logic [XLEN-1:0]   cap_data;
  logic              cap_err;

  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   wdata;
  logic [XLEN-1:0]   ld_data;
  logic [1:0]        eff_lo;
  logic [2:0]        eff_size;
  logic              mis;

  dmem_align #(.XLEN(XLEN)) u_align (
    .addr_lo     (adr_i[1:0]),
    .size        (access_size_i),
    .store_data  (store_data_i),
    .ld_addr_lo  (cap_lo),
    .ld_size     (cap_size),
    .rdata       (rdata_i),
    .be          (be),
    .wdata       (wdata),
    .ld_data     (ld_data),
    .eff_addr_lo (eff_lo),
    .eff_size    (eff_size),
    .misaligned  (mis)
  );

  // Last REQ/WAIT cycle before the access is abandoned.
  assign hit = (cnt == TO_LAST);

  // State and timeout counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, handshake outputs and capture strobes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req       = 1'b0;
    stall     = 1'b0;
    mis_pulse = 1'b0;
    cap_req   = 1'b0;
    cap_rsp   = 1'b0;
    cap_to    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (adr_v_i) begin
          if (mis) begin
            mis_pulse = 1'b1;
          end else begin
            req       = 1'b1;
            stall     = 1'b1;
            cap_req   = 1'b1;
            state_nxt = gnt_i ? WAIT : REQ;
          end
        end
      end
      REQ: begin
        req     = 1'b1;
        stall   = 1'b1;
        cnt_nxt = cnt + 16'd1;
        if (hit) begin
          cap_to    = 1'b1;
          state_nxt = DONE;
        end else if (gnt_i) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        stall   = 1'b1;
        cnt_nxt = cnt + 16'd1;
        // A response in the final cycle still counts as a normal completion.
        if (rvalid_i) begin
          cap_rsp   = 1'b1;
          state_nxt = DONE;
        end else if (hit) begin
          cap_to    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Access attributes at issue; response data/error at completion or timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_lo    <= '0;
      cap_size  <= '0;
      cap_store <= 1'b0;
      cap_data  <= '0;
      cap_err   <= 1'b0;
    end else begin
      if (cap_req) begin
        cap_lo    <= eff_lo;
        cap_size  <= eff_size;
        cap_store <= is_store_i;
        cap_data  <= '0;
        cap_err   <= 1'b0;
      end
      if (cap_rsp) begin
        cap_data <= cap_store ? '0 : ld_data;
        cap_err  <= err_i;
      end
      if (cap_to) begin
        cap_data <= '0;
        cap_err  <= 1'b1;
      end
    end
  end

  // Request-side outputs are gated by reset so a stalled access cannot leak
  // a request while the controller is held in reset.
  assign req_o        = req & reset_n;
  assign stall_o      = stall & reset_n;
  assign misaligned_o = mis_pulse & reset_n;
  assign we_o         = req_o & is_store_i;
  assign be_o         = req_o ? be : '0;
  assign addr_o       = {adr_i[XLEN-1:2], 2'b00};
  assign wdata_o      = wdata;
  assign load_data_o  = (state == DONE) ? cap_data : '0;
  assign bus_err_o    = (state == DONE) & cap_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl with a short timeout (4 cycles).
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        adr_v_i;
  logic [31:0] adr_i;
  logic        is_store_i;
  logic [31:0] store_data_i;
  logic [2:0]  access_size_i;
  logic [31:0] load_data_o;
  logic        stall_o, misaligned_o, bus_err_o, req_o, gnt_i, we_o;
  logic [3:0]  be_o;
  logic [31:0] addr_o, wdata_o;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic        err_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .adr_v_i       (adr_v_i),
    .adr_i         (adr_i),
    .is_store_i    (is_store_i),
    .store_data_i  (store_data_i),
    .access_size_i (access_size_i),
    .load_data_o   (load_data_o),
    .stall_o       (stall_o),
    .misaligned_o  (misaligned_o),
    .bus_err_o     (bus_err_o),
    .req_o         (req_o),
    .gnt_i         (gnt_i),
    .we_o          (we_o),
    .be_o          (be_o),
    .addr_o        (addr_o),
    .wdata_o       (wdata_o),
    .rvalid_i      (rvalid_i),
    .rdata_i       (rdata_i),
    .err_i         (err_i)
  );

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  size;
    logic        st;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [2:0] sz, input logic st, input logic [31:0] sd);
    adr_v_i       = 1'b1;
    adr_i         = a;
    access_size_i = sz;
    is_store_i    = st;
    store_data_i  = sd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cycles;
    //            adr           size    st    sdata         rdata         be       addr          wdata         load
    vecs[0] = '{32'h0000_0104, 3'b010, 1'b0, 32'h1122_3344, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0104, 32'h1122_3344, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0203, 3'b000, 1'b1, 32'h0000_00A5, 32'h0000_0000, 4'b1000, 32'h0000_0200, 32'hA5A5_A5A5, 32'h0000_0000};
    vecs[2] = '{32'h0000_0101, 3'b000, 1'b0, 32'h0000_0000, 32'h1234_5678, 4'b0010, 32'h0000_0100, 32'h0000_0000, 32'h0000_0056};
    vecs[3] = '{32'h0000_0102, 3'b001, 1'b0, 32'h0000_0000, 32'hCAFE_BABE, 4'b1100, 32'h0000_0100, 32'h0000_0000, 32'h0000_CAFE};
    vecs[4] = '{32'h0000_0106, 3'b001, 1'b1, 32'h1234_BEEF, 32'h0000_0000, 4'b1100, 32'h0000_0104, 32'hBEEF_BEEF, 32'h0000_0000};
    vecs[5] = '{32'h0000_0008, 3'b010, 1'b1, 32'h89AB_CDEF, 32'h0000_0000, 4'b1111, 32'h0000_0008, 32'h89AB_CDEF, 32'h0000_0000};
    vecs[6] = '{32'h0000_000C, 3'b111, 1'b0, 32'h0000_0000, 32'h0F0F_0F0F, 4'b1111, 32'h0000_000C, 32'h0000_0000, 32'h0F0F_0F0F};
    vecs[7] = '{32'h0000_0003, 3'b000, 1'b0, 32'h0000_0000, 32'hA1B2_C3D4, 4'b1000, 32'h0000_0000, 32'h0000_0000, 32'h0000_00A1};

    reset_n = 1'b0;
    adr_v_i = 1'b0; adr_i = '0; is_store_i = 1'b0; store_data_i = '0; access_size_i = 3'b010;
    gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; err_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, req_o}, 32'd0);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_mis", {31'b0, misaligned_o}, 32'd0);
    chk("rst_err", {31'b0, bus_err_o}, 32'd0);
    chk("rst_we", {31'b0, we_o}, 32'd0);
    chk("rst_be", {28'b0, be_o}, 32'd0);
    chk("rst_load", load_data_o, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Best-case accesses, back to back: issue+gnt, rvalid, DONE.
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      issue(vecs[i].adr, vecs[i].size, vecs[i].st, vecs[i].sdata);
      gnt_i = 1'b1; rvalid_i = 1'b0;
      #1;
      chk("v_req", {31'b0, req_o}, 32'd1);
      chk("v_stall0", {31'b0, stall_o}, 32'd1);
      chk("v_be", {28'b0, be_o}, {28'b0, vecs[i].exp_be});
      chk("v_addr", addr_o, vecs[i].exp_addr);
      chk("v_we", {31'b0, we_o}, {31'b0, vecs[i].st});
      if (vecs[i].st) chk("v_wdata", wdata_o, vecs[i].exp_wdata);
      next_cycle();
      gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = vecs[i].rdata;
      #1;
      chk("v_req_wait", {31'b0, req_o}, 32'd0);
      chk("v_stall1", {31'b0, stall_o}, 32'd1);
      next_cycle();
      rvalid_i = 1'b0; rdata_i = '0;
      #1;
      chk("v_stall_done", {31'b0, stall_o}, 32'd0);
      chk("v_req_done", {31'b0, req_o}, 32'd0);
      chk("v_load", load_data_o, vecs[i].exp_load);
      chk("v_err", {31'b0, bus_err_o}, 32'd0);
    end
    next_cycle();
    adr_v_i = 1'b0;
    #1;
    chk("idle_load", load_data_o, 32'd0);

    // Delayed grant half load, with a stray rvalid while in REQ.
    req_cycles = 0;
    next_cycle();
    issue(32'h0000_0302, 3'b001, 1'b0, 32'h0);
    gnt_i = 1'b0;
    #1;
    req_cycles += int'(req_o);
    chk("dg_be", {28'b0, be_o}, 32'h0000_000C);
    chk("dg_addr", addr_o, 32'h0000_0300);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      gnt_i = (k == 3);
      rvalid_i = (k == 1);
      rdata_i = (k == 1) ? 32'h5555_5555 : 32'h0;
      #1;
      req_cycles += int'(req_o);
      chk("dg_stall", {31'b0, stall_o}, 32'd1);
    end
    next_cycle();
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h8001_7FFF;
    #1;
    req_cycles += int'(req_o);
    chk("dg_wait_stall", {31'b0, stall_o}, 32'd1);
    next_cycle();
    rvalid_i = 1'b0; rdata_i = '0;
    #1;
    chk("dg_req_cycles", req_cycles, 32'd4);
    chk("dg_load", load_data_o, 32'h0000_8001);
    chk("dg_stall_done", {31'b0, stall_o}, 32'd0);
    next_cycle();
    adr_v_i = 1'b0;

    // Timeout: never granted.
    next_cycle();
    issue(32'h0000_0400, 3'b010, 1'b0, 32'h0);
    gnt_i = 1'b0; rdata_i = 32'hFFFF_FFFF;
    #1;
    chk("to_req0", {31'b0, req_o}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      chk("to_req", {31'b0, req_o}, 32'd1);
      chk("to_stall", {31'b0, stall_o}, 32'd1);
    end
    next_cycle();
    chk("to_done_req", {31'b0, req_o}, 32'd0);
    chk("to_done_stall", {31'b0, stall_o}, 32'd0);
    chk("to_done_err", {31'b0, bus_err_o}, 32'd1);
    chk("to_done_load", load_data_o, 32'd0);
    next_cycle();
    adr_v_i = 1'b0; rdata_i = '0;
    #1;
    chk("to_err_pulse", {31'b0, bus_err_o}, 32'd0);

    // Error response; also rvalid in the grant cycle must be ignored.
    next_cycle();
    issue(32'h0000_0500, 3'b010, 1'b0, 32'h0);
    gnt_i = 1'b1; rvalid_i = 1'b1; rdata_i = 32'h0BAD_0BAD;
    next_cycle();
    gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
    #1;
    chk("er_wait_stall", {31'b0, stall_o}, 32'd1);
    next_cycle();
    rvalid_i = 1'b1; err_i = 1'b1; rdata_i = 32'h1234_5678;
    #1;
    chk("er_stall", {31'b0, stall_o}, 32'd1);
    next_cycle();
    rvalid_i = 1'b0; err_i = 1'b0; rdata_i = '0;
    #1;
    chk("er_err", {31'b0, bus_err_o}, 32'd1);
    chk("er_load", load_data_o, 32'h1234_5678);
    next_cycle();
    adr_v_i = 1'b0;
    #1;
    chk("er_err_pulse", {31'b0, bus_err_o}, 32'd0);

    // Misaligned word load at 0x101.
    next_cycle();
    issue(32'h0000_0101, 3'b010, 1'b0, 32'h0);
    gnt_i = 1'b1;
    #1;
`ifdef DMEM_CTRL_MISALIGN_CHECK_EN
    chk("mis_flag", {31'b0, misaligned_o}, 32'd1);
    chk("mis_req", {31'b0, req_o}, 32'd0);
    chk("mis_stall", {31'b0, stall_o}, 32'd0);
    next_cycle();
    adr_v_i = 1'b0; gnt_i = 1'b0;
    #1;
    chk("mis_pulse", {31'b0, misaligned_o}, 32'd0);
    chk("mis_stall1", {31'b0, stall_o}, 32'd0);
`else
    chk("mis_flag", {31'b0, misaligned_o}, 32'd0);
    chk("mis_req", {31'b0, req_o}, 32'd1);
    chk("mis_be", {28'b0, be_o}, 32'h0000_000F);
    chk("mis_addr", addr_o, 32'h0000_0100);
    next_cycle();
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h1122_3344;
    next_cycle();
    rvalid_i = 1'b0; rdata_i = '0;
    #1;
    chk("mis_load", load_data_o, 32'h1122_3344);
    next_cycle();
    adr_v_i = 1'b0;
`endif

    // Reset while in WAIT, then a late rvalid.
    next_cycle();
    issue(32'h0000_0600, 3'b010, 1'b0, 32'h0);
    gnt_i = 1'b1;
    next_cycle();
    gnt_i = 1'b0;
    #1;
    chk("rw_wait_stall", {31'b0, stall_o}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rw_rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rw_rst_req", {31'b0, req_o}, 32'd0);
    next_cycle();
    reset_n = 1'b1; adr_v_i = 1'b0;
    next_cycle();
    rvalid_i = 1'b1; rdata_i = 32'hFFFF_FFFF;
    #1;
    chk("rw_late_stall", {31'b0, stall_o}, 32'd0);
    next_cycle();
    rvalid_i = 1'b0; rdata_i = '0;
    #1;
    chk("rw_no_done_load", load_data_o, 32'd0);
    chk("rw_no_done_err", {31'b0, bus_err_o}, 32'd0);
    chk("rw_idle_stall", {31'b0, stall_o}, 32'd0);

    // Controller must be usable again after the reset.
    next_cycle();
    issue(32'h0000_0700, 3'b010, 1'b0, 32'h0);
    gnt_i = 1'b1;
    #1;
    chk("rw_new_req", {31'b0, req_o}, 32'd1);
    next_cycle();
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h0000_0055;
    next_cycle();
    rvalid_i = 1'b0; rdata_i = '0;
    #1;
    chk("rw_new_load", load_data_o, 32'h0000_0055);
    next_cycle();
    adr_v_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
